// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator: next-PC modes, FSM states
// and the per-cycle control bundle that the FSM hands to the PC datapath.
package pc_pkg;

    typedef enum logic [2:0] {
        MODE_SEQ    = 3'd0,
        MODE_BRANCH = 3'd1,
        MODE_JUMP   = 3'd2,
        MODE_JUMPR  = 3'd3,
        MODE_ERET   = 3'd4
    } pc_mode_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // One-hot-ish actions for the datapath; load_trap wins over load_target.
    typedef struct packed {
        logic load_trap;
        logic load_target;
        logic save_epc;
        logic misalign;
    } pc_ctrl_t;

endpackage

// File: rtl/pc_target.sv
// Combinational next-PC target selection and alignment check.
// Only redirecting targets are checked; sequential and not-taken paths are not.
module pc_target
    import pc_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [2:0]          mode,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] imm,
    input  logic [PC_WIDTH-1:0] rs1,
    input  logic [PC_WIDTH-1:0] epc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] target,
    output logic                misaligned
);

    logic [PC_WIDTH-1:0] jr_sum;
    logic                check;

    always_comb begin
        pc_plus4 = pc + PC_WIDTH'(4);
        jr_sum   = rs1 + imm;
        target   = pc_plus4;
        check    = 1'b0;
        case (mode)
            MODE_BRANCH: begin
                if (br_taken) begin
                    target = pc + imm;
                    check  = 1'b1;
                end
            end
            MODE_JUMP: begin
                target = pc + imm;
                check  = 1'b1;
            end
            MODE_JUMPR: begin
                // Register jumps drop bit 0 before the alignment test.
                target = {jr_sum[PC_WIDTH-1:1], 1'b0};
                check  = 1'b1;
            end
            MODE_ERET: begin
                target = epc;
                check  = 1'b1;
            end
            default: begin
                target = pc_plus4;
                check  = 1'b0;
            end
        endcase
        misaligned = check & (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control, trap and misalign
// redirects, and a valid/ready fetch request port.
module pc_gen
    import pc_pkg::*;
#(
    parameter int          PC_WIDTH   = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned RESET_VEC  = 0,
    parameter int unsigned TRAP_VEC   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mode,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic                  stall,
    input  logic                  trap_req,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_plus4,
    output logic [PC_WIDTH-1:0]   epc,
    output logic                  misalign_err,
    output pc_state_e             dbg_state
);

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VEC);
    localparam logic [PC_WIDTH-1:0] TRAP_PC  = PC_WIDTH'(TRAP_VEC);

    // Fetch handshake: a request is offered while fetch_valid is high and is
    // consumed on a rising edge where fetch_ready is also high; the PC holds
    // its value until then, and only a trap may redirect an unaccepted request.

    pc_state_e           state;
    pc_state_e           state_nxt;
    pc_ctrl_t            ctrl;
    logic [PC_WIDTH-1:0] target;
    logic                target_mis;
    logic                adv;
    logic                misalign_hit;
    logic                unused_hi;

    // Operands wider than the PC contribute only their low bits.
    assign unused_hi = ^{imm, rs1};

    pc_target #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target (
        .mode       (mode),
        .br_taken   (br_taken),
        .pc         (pc),
        .imm        (imm[PC_WIDTH-1:0]),
        .rs1        (rs1[PC_WIDTH-1:0]),
        .epc        (epc),
        .pc_plus4   (pc_plus4),
        .target     (target),
        .misaligned (target_mis)
    );

    assign fetch_valid  = (state == ST_RUN) & ~stall;
    assign adv          = fetch_valid & fetch_ready & ~stall;
    assign misalign_hit = adv & target_mis;
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (trap_req || misalign_hit) begin
                    state_nxt = ST_RUN;
                end else if (halt_req) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (trap_req) begin
                    state_nxt = ST_RUN;
                end else if (resume && !halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Redirect priority: trap, misalign, halt, stall, then normal advance.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_RUN: begin
                if (trap_req) begin
                    ctrl.load_trap = 1'b1;
                    ctrl.save_epc  = 1'b1;
                end else if (misalign_hit) begin
                    ctrl.load_trap = 1'b1;
                    ctrl.save_epc  = 1'b1;
                    ctrl.misalign  = 1'b1;
                end else if (halt_req) begin
                    ctrl = '0;
                end else if (adv) begin
                    ctrl.load_target = 1'b1;
                end
            end
            ST_HALT: begin
                if (trap_req) begin
                    ctrl.load_trap = 1'b1;
                    ctrl.save_epc  = 1'b1;
                end
            end
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            epc          <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= ctrl.misalign;
            if (ctrl.save_epc) begin
                epc <= pc;
            end
            if (ctrl.load_trap) begin
                pc <= TRAP_PC;
            end else if (ctrl.load_target) begin
                pc <= target;
            end
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of PC and all address outputs, min 8.
REQ-002 Parameter DATA_WIDTH, default 32: width of imm and rs1 operands, DATA_WIDTH >= PC_WIDTH.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset, word-aligned.
REQ-004 Parameter TRAP_VEC, default 'h100: PC value loaded on trap or misalign, word-aligned.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 mode  in  3  next-PC mode: SEQ, BRANCH, JUMP, JUMPR, ERET.
REQ-008 br_taken  in  1  branch condition, used only in BRANCH mode.
REQ-009 imm  in  DATA_WIDTH  immediate offset, low PC_WIDTH bits used.
REQ-010 rs1  in  DATA_WIDTH  register base for JUMPR, low PC_WIDTH bits used.
REQ-011 stall  in  1  holds PC and suppresses advance.
REQ-012 trap_req  in  1  external trap, highest priority redirect.
REQ-013 halt_req / resume  in  1 each  enter and leave HALT.
REQ-014 fetch_valid  out  1  PC is a valid fetch request.
REQ-015 fetch_ready  in  1  instruction memory accepts request.
REQ-016 pc  out  PC_WIDTH  current fetch address.
REQ-017 pc_plus4  out  PC_WIDTH  pc+4, link value, combinational.
REQ-018 epc  out  PC_WIDTH  saved exception PC.
REQ-019 misalign_err  out  1  one-cycle pulse on misaligned computed target.

Function
REQ-020 The block SHALL implement FSM states BOOT, RUN, HALT.
REQ-021 BOOT SHALL last exactly one cycle after rst_n deasserts, with fetch_valid=0, then go to RUN.
REQ-022 In RUN, fetch_valid SHALL be 1 unless stall=1.
REQ-023 Advance SHALL be adv = fetch_valid & fetch_ready & ~stall; pc changes only on adv or redirect.
REQ-024 While fetch_valid=1 and fetch_ready=0, pc SHALL stay stable except on trap_req.
REQ-025 Next PC on adv SHALL be: SEQ pc+4; BRANCH pc+imm if br_taken else pc+4; JUMP pc+imm; JUMPR (rs1+imm) with bit0 cleared; ERET epc.
REQ-026 All PC arithmetic SHALL be modulo 2^PC_WIDTH, wrapping silently.
REQ-027 If the selected non-SEQ target has bits[1:0] != 0 after JUMPR masking, the block SHALL pulse misalign_err, load pc=TRAP_VEC and load epc=current pc.
REQ-028 A not-taken BRANCH SHALL NOT check imm alignment.
REQ-029 trap_req=1 in RUN or HALT SHALL load pc=TRAP_VEC, epc=current pc, next state RUN, regardless of stall, fetch_ready and halt_req.
REQ-030 Priority SHALL be trap_req > misalign > halt_req > stall > adv.
REQ-031 halt_req=1 in RUN without trap SHALL go to HALT next cycle with pc held; fetch_valid=0 in HALT.
REQ-032 resume=1 in HALT SHALL return to RUN next cycle with pc unchanged; simultaneous halt_req and resume in HALT SHALL stay in HALT.
REQ-033 Unused mode encodings SHALL behave as SEQ.
REQ-034 epc SHALL change only on trap or misalign.

Reset
REQ-035 On rst_n=0 the block SHALL asynchronously set pc=RESET_VEC, epc=RESET_VEC, state=BOOT, fetch_valid=0, misalign_err=0.
REQ-036 Reset asserted mid-request SHALL drop fetch_valid in the same cycle without waiting for fetch_ready.

Structure
REQ-037 Mode enum and FSM state enum SHALL be defined in a shared package pc_pkg.
REQ-038 The target adder and alignment check SHALL be one sub-module pc_target, combinational.

Verification
REQ-039 Reset release, fetch_ready=1, mode=SEQ for 4 cycles -> one BOOT cycle with fetch_valid=0, then pc 0,4,8,12.
REQ-040 pc=0x10, mode=BRANCH, imm=-8, br_taken=1, adv -> pc=0x08; same with br_taken=0 -> pc=0x14.
REQ-041 pc=0x20, fetch_ready=0 for 3 cycles -> pc held at 0x20, fetch_valid=1; trap_req in 2nd cycle -> pc=TRAP_VEC, epc=0x20.
REQ-042 mode=JUMPR, rs1=0x31, imm=0x1 -> target 0x32 misaligned -> misalign_err one cycle, pc=TRAP_VEC, epc=old pc; then mode=ERET -> pc=old pc.
REQ-043 PC_WIDTH=8, pc=0xFC, SEQ adv -> pc=0x00, no error.
REQ-044 halt_req in RUN -> HALT, fetch_valid=0, pc held; resume -> RUN, pc unchanged; rst_n pulse mid-HALT -> pc=RESET_VEC, state BOOT.
